priority_arbiter_n: RTL and testbench

PRIORITY_ARBITER_N -- requirements
Module: priority_arbiter_n

---
 rtl/priority_arbiter_n.sv | 125 ++++++++++++
 tb/tb_priority_arbiter_n.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_n.sv
// -----------------------------------------------------------------------------
// priority_arbiter_n
//   N-channel arbiter with a registered one-hot grant held until the grantee
//   signals done. Default selection is fixed priority (highest asserted index
//   wins). Defining the macro PRIO_ARB_RR_EN switches selection to round-robin
//   starting after the last-granted channel.
//
// Parameters
//   N          number of request channels (2..32)
//   W          width of the grant index, $clog2(N)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req        [N-1:0] level-sensitive request per channel
//   done       current grantee releases the grant this cycle
//   gnt        [N-1:0] registered one-hot grant (zero when idle)
//   gnt_idx    [W-1:0] registered binary index of the granted channel
//   gnt_valid  registered, high while a grant is held
// -----------------------------------------------------------------------------
module priority_arbiter_n #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_gnt;
    logic [W-1:0] r_gnt_idx;
    logic         r_gnt_valid;
    logic [W-1:0] r_ptr;

    logic [W-1:0] w_win_idx;
    logic [W-1:0] w_cand;
    logic         w_found;
    logic         w_any;

    assign w_any = |req;

    // Both modes walk the channels in rotated order starting at r_ptr+1.
    // Round-robin keeps the first hit; fixed priority keeps the highest index
    // seen, which is independent of the starting point since every channel is
    // visited exactly once.
    always_comb begin
        w_win_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = W'((32'(r_ptr) + k) % N);
`ifdef PRIO_ARB_RR_EN
            if (req[w_cand] && !w_found) begin
                w_win_idx = w_cand;
                w_found   = 1'b1;
            end
`else
            if (req[w_cand] && (!w_found || (w_cand > w_win_idx))) begin
                w_win_idx = w_cand;
                w_found   = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= W'(N - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // done is ignored here: only a request starts a grant
                    if (w_any) begin
                        r_state     <= ST_GRANT;
                        r_gnt       <= {{(N-1){1'b0}}, 1'b1} << w_win_idx;
                        r_gnt_idx   <= w_win_idx;
                        r_gnt_valid <= 1'b1;
                        r_ptr       <= w_win_idx;
                    end
                end
                ST_GRANT: begin
                    if (done) begin
                        if (w_any) begin
                            // back-to-back re-arbitration, no idle cycle
                            r_gnt       <= {{(N-1){1'b0}}, 1'b1} << w_win_idx;
                            r_gnt_idx   <= w_win_idx;
                            r_gnt_valid <= 1'b1;
                            r_ptr       <= w_win_idx;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_gnt       <= '0;
                            r_gnt_idx   <= '0;
                            r_gnt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= '0;
                    r_gnt_idx   <= '0;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_priority_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_priority_arbiter_n
//   Bench for priority_arbiter_n with N=4. A behavioural model tracks the
//   expected grant; a negedge process compares the DUT against it every cycle.
//   Directed scenarios pin the model with literal expectations, then random
//   traffic (with occasional resets) exercises the rest. Honours
//   PRIO_ARB_RR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_priority_arbiter_n;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_idx;
    logic         gnt_valid;

    int n_cmp = 0;
    int n_bad = 0;

    priority_arbiter_n #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_init  = 1'b0;
    bit m_valid = 1'b0;
    int m_idx   = 0;
    int m_ptr   = N - 1;

    function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef PRIO_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (r[j]) return j;
        end
        return 0;
`else
        for (int i = N - 1; i >= 0; i--)
            if (r[i]) return i;
        return 0;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init  = 1'b1;
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = N - 1;
        end else if (!m_valid || done) begin
            if (req != '0) begin
                m_idx   = pick(req, m_ptr);
                m_valid = 1'b1;
                m_ptr   = m_idx;
            end else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (m_init) begin
            chk("model_gnt_valid", 32'(gnt_valid), 32'(m_valid));
            chk("model_gnt_idx",   32'(gnt_idx),   32'(m_valid ? m_idx : 0));
            chk("model_gnt",       32'(gnt),       m_valid ? (32'd1 << m_idx) : 32'd0);
            chk("inv_onehot",      32'($countones(gnt) <= 1), 32'd1);
            chk("inv_gnt_at_idx",  32'(gnt[gnt_idx]), 32'(gnt_valid));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r_rst, input logic [N-1:0] r_req, input logic r_done);
        @(negedge clk);
        rst  = r_rst;
        req  = r_req;
        done = r_done;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [N-1:0] e_gnt, input int e_idx, input logic e_v);
        chk({name, "_gnt"},   32'(gnt),       32'(e_gnt));
        chk({name, "_idx"},   32'(gnt_idx),   32'(e_idx));
        chk({name, "_valid"}, 32'(gnt_valid), 32'(e_v));
    endtask

    initial begin
        int seq_rr [5];
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        seq_rr = '{0, 1, 2, 3, 0};

        // reset, with requests and done asserted to show reset overrides them
        step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b0000, 1'b0);
        lit("reset", 4'b0000, 0, 1'b0);

        // first grant with 1-cycle latency, then hold while req changes
        step(1'b0, 4'b0101, 1'b0);
`ifdef PRIO_ARB_RR_EN
        lit("first", 4'b0001, 0, 1'b1);
`else
        lit("first", 4'b0100, 2, 1'b1);
`endif
        step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
`ifdef PRIO_ARB_RR_EN
        lit("hold", 4'b0001, 0, 1'b1);
`else
        lit("hold", 4'b0100, 2, 1'b1);
`endif

        // release with new requests: re-arbitrate without a gap
        step(1'b0, 4'b1001, 1'b1);
        lit("rearb", 4'b1000, 3, 1'b1);

        // release with no requests returns to idle, done in idle is ignored
        step(1'b0, 4'b0000, 1'b1);
        lit("release", 4'b0000, 0, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        lit("idle_done", 4'b0000, 0, 1'b0);

        // all requesting, done on every grant
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
`ifdef PRIO_ARB_RR_EN
        chk("seq0", 32'(gnt_idx), 32'(seq_rr[0]));
`else
        chk("seq0", 32'(gnt_idx), 32'd3);
`endif
        for (int i = 1; i < 5; i++) begin
            step(1'b0, 4'b1111, 1'b1);
`ifdef PRIO_ARB_RR_EN
            chk($sformatf("seq%0d", i), 32'(gnt_idx), 32'(seq_rr[i]));
`else
            chk($sformatf("seq%0d", i), 32'(gnt_idx), 32'd3);
`endif
        end

        // reset mid-grant drops the grant, then first grant after release
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0010, 1'b0);
        lit("pre_rst", 4'b0010, 1, 1'b1);
        step(1'b1, 4'b1111, 1'b0);
        lit("mid_rst", 4'b0000, 0, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
`ifdef PRIO_ARB_RR_EN
        lit("post_rst", 4'b0001, 0, 1'b1);
`else
        lit("post_rst", 4'b1000, 3, 1'b1);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            step(($urandom_range(0, 59) == 0), r, ($urandom_range(0, 2) == 0));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
